pipe_add_sub: RTL and testbench
===============================

Name: pipe_add_sub

Overview:
Parametrised, pipelined integer adder/subtractor for the SimpleRisc ALU datapath, the successor to the 32-bit single-cycle ripple adder. Splits a WIDTH-bit add into STAGES chunks of WIDTH/STAGES bits, one chunk per pipeline stage, with the carry registered between stages. Supports add, subtract and add-with-carry. Produces carry, overflow, zero and negative flags. Uses a valid/ready handshake with full backpressure.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth = number of chunks; 1..WIDTH; CHUNK = WIDTH/STAGES.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid this cycle
in_ready  output  1  block accepts input this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  2  00=ADD (a+b), 01=SUB (a-b), 10=ADC (a+b+in_cin), 11=SBC (a+~b+in_cin)
in_cin  input  1  carry in; used only for ADC/SBC
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  result
out_cout  output  1  carry out of MSB (for SUB: 1 = no borrow)
out_ovf  output  1  signed overflow
out_zero  output  1  out_sum == 0
out_neg  output  1  out_sum[WIDTH-1]

Behaviour:
- Reset (rst_n low, async): all stage valid bits, out_valid, out_sum, flags cleared to 0; in_ready = 1 one cycle after deassertion and beyond, combinationally derived. Reset mid-operation discards all in-flight items; no partial output.
- Operand prep at accept: b_eff = ~in_b for SUB/SBC, else in_b; c0 = 1 for SUB, 0 for ADD, in_cin for ADC/SBC.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff plus the registered carry from stage k-1 (c0 for k=0); registers chunk sum, carry, running zero AND (chunk==0 && prior zero), and forwards the not-yet-used upper chunks of a/b_eff.
- Last stage: out_cout = carry out of bit WIDTH-1; out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; out_neg = sum MSB; out_zero = running zero.
- Latency: exactly STAGES cycles from accepted input (in_valid && in_ready) to out_valid with no stall. Throughput 1 op/cycle.
- Handshake: stall = out_valid && !out_ready. When stall, every stage holds (global enable); in_ready = !stall. Input accepted on in_valid && in_ready. Output retires on out_valid && out_ready. out_* stable while out_valid && !out_ready.
- Bubbles are carried, not collapsed: a stage with valid=0 moves through; ready depends only on the output stage.
- Simultaneous accept and retire in the same cycle is allowed with no loss or duplication.
- Arithmetic is modulo 2^WIDTH; no saturation. Ordering is strictly in-order.
- STAGES=1 degenerates to a single registered adder, latency 1.

Test Plan:
- ADD, WIDTH=32, STAGES=4: a=0x0000_FFFF, b=0x0000_0001 -> after 4 cycles sum=0x0001_0000, cout=0, ovf=0, zero=0, neg=0 (carry crosses chunk boundary).
- SUB: a=5, b=5 -> sum=0, zero=1, cout=1; a=3, b=5 -> sum=0xFFFF_FFFE, neg=1, cout=0 (borrow).
- Overflow: ADD a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, neg=1; ADC a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0.
- Backpressure: stream 8 back-to-back ops, hold out_ready=0 for 3 cycles mid-stream -> in_ready low during stall, out_sum stable, all 8 results emerge in order, none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with 3 items in pipe -> out_valid=0 immediately, no stale result appears after release.
- Params sweep: WIDTH=8 STAGES=1 and WIDTH=64 STAGES=8 random ops vs reference model -> latency equals STAGES, all outputs match.

Source files
------------

// File: rtl/pipe_add_sub.sv
// Pipelined integer add/subtract: one CHUNK-bit slice per stage with the carry registered
// between stages, valid/ready handshake with a global stall when the output is blocked.
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);
  localparam int CHUNK = WIDTH / STAGES;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  logic             stall;
  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Only a blocked output stage can stall; bubbles flow through freely.
  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    b_eff = in_b;
    c0    = 1'b0;
    case (op_e'(in_op))
      OP_ADD: begin
        b_eff = in_b;
        c0    = 1'b0;
      end
      OP_SUB: begin
        b_eff = ~in_b;
        c0    = 1'b1;
      end
      OP_ADC: begin
        b_eff = in_b;
        c0    = in_cin;
      end
      OP_SBC: begin
        b_eff = ~in_b;
        c0    = in_cin;
      end
      default: begin
        b_eff = in_b;
        c0    = 1'b0;
      end
    endcase
  end

  // Stage k consumes the lowest remaining chunk and forwards only the still-unused upper bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W  = WIDTH - k * CHUNK;
    localparam int ACC_W = (k + 1) * CHUNK;

    logic             prev_valid;
    logic             prev_carry;
    logic             prev_zero;
    logic [IN_W-1:0]  prev_a;
    logic [IN_W-1:0]  prev_b;
    logic [CHUNK:0]   chunk_res;
    logic [ACC_W-1:0] next_sum;
    logic             valid_q;
    logic             carry_q;
    logic             zero_q;
    logic [ACC_W-1:0] sum_q;

    if (k == 0) begin : g_src
      assign prev_valid = accept;
      assign prev_a     = in_a;
      assign prev_b     = b_eff;
      assign prev_carry = c0;
      assign prev_zero  = 1'b1;
      assign next_sum   = chunk_res[CHUNK-1:0];
    end else begin : g_src
      assign prev_valid = g_stage[k-1].valid_q;
      assign prev_a     = g_stage[k-1].g_fwd.rem_a;
      assign prev_b     = g_stage[k-1].g_fwd.rem_b;
      assign prev_carry = g_stage[k-1].carry_q;
      assign prev_zero  = g_stage[k-1].zero_q;
      assign next_sum   = {chunk_res[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    assign chunk_res = {1'b0, prev_a[CHUNK-1:0]} + {1'b0, prev_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, prev_carry};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        zero_q  <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= prev_valid;
        carry_q <= chunk_res[CHUNK];
        zero_q  <= prev_zero && (chunk_res[CHUNK-1:0] == '0);
        sum_q   <= next_sum;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IN_W-CHUNK-1:0] rem_a;
      logic [IN_W-CHUNK-1:0] rem_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_a <= '0;
          rem_b <= '0;
        end else if (advance) begin
          rem_a <= prev_a[IN_W-1:CHUNK];
          rem_b <= prev_b[IN_W-1:CHUNK];
        end
      end
    end else begin : g_ovf
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB's own sum bit and operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= prev_a[CHUNK-1] ^ prev_b[CHUNK-1] ^ chunk_res[CHUNK-1] ^ chunk_res[CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].carry_q;
  assign out_zero  = g_stage[STAGES-1].zero_q;
  assign out_ovf   = g_stage[STAGES-1].g_ovf.ovf_q;
  assign out_neg   = g_stage[STAGES-1].sum_q[WIDTH-1];

endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub: 32/4 main instance plus 8/1 and 64/8 parameter variants,
// all checked against a plain full-width arithmetic model.
module tb_pipe_add_sub;
  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    int          cyc;
  } item_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] sum;
    logic [3:0]  flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  item_t q32[$];
  item_t q8[$];
  item_t q64[$];

  logic        in_valid, in_ready, in_cin, out_valid, out_ready;
  logic        out_cout, out_ovf, out_zero, out_neg;
  logic [31:0] in_a, in_b, out_sum;
  logic [1:0]  in_op;

  logic        p8_in_valid, p8_in_ready, p8_in_cin, p8_out_valid, p8_out_ready;
  logic        p8_out_cout, p8_out_ovf, p8_out_zero, p8_out_neg;
  logic [7:0]  p8_in_a, p8_in_b, p8_out_sum;
  logic [1:0]  p8_in_op;

  logic        p64_in_valid, p64_in_ready, p64_in_cin, p64_out_valid, p64_out_ready;
  logic        p64_out_cout, p64_out_ovf, p64_out_zero, p64_out_neg;
  logic [63:0] p64_in_a, p64_in_b, p64_out_sum;
  logic [1:0]  p64_in_op;

  pipe_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(p8_in_valid), .in_ready(p8_in_ready), .in_a(p8_in_a),
    .in_b(p8_in_b), .in_op(p8_in_op), .in_cin(p8_in_cin), .out_valid(p8_out_valid),
    .out_ready(p8_out_ready), .out_sum(p8_out_sum), .out_cout(p8_out_cout), .out_ovf(p8_out_ovf),
    .out_zero(p8_out_zero), .out_neg(p8_out_neg)
  );

  pipe_add_sub #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(p64_in_valid), .in_ready(p64_in_ready), .in_a(p64_in_a),
    .in_b(p64_in_b), .in_op(p64_in_op), .in_cin(p64_in_cin), .out_valid(p64_out_valid),
    .out_ready(p64_out_ready), .out_sum(p64_out_sum), .out_cout(p64_out_cout), .out_ovf(p64_out_ovf),
    .out_zero(p64_out_zero), .out_neg(p64_out_neg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: one full-width addition, carry into the MSB from a separate (w-1)-bit addition.
  function automatic item_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] op, input logic cin, input int w);
    logic [64:0] mask, full, low;
    logic [63:0] aa, be;
    logic        c0;
    item_t       r;
    mask = (65'd1 << w) - 65'd1;
    aa   = a & mask[63:0];
    be   = (op[0] ? ~b : b) & mask[63:0];
    c0   = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : cin;
    full = {1'b0, aa} + {1'b0, be} + {64'd0, c0};
    low  = ({1'b0, aa} & (mask >> 1)) + ({1'b0, be} & (mask >> 1)) + {64'd0, c0};
    r      = '0;
    r.sum  = full[63:0] & mask[63:0];
    r.cout = full[w];
    r.ovf  = low[w-1] ^ full[w];
    r.zero = (r.sum == 64'd0);
    r.neg  = r.sum[w-1];
    return r;
  endfunction

  // Drives one cycle on the main instance; pushes on accept, pops on retire.
  task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic c, input logic rdy, output logic acc, output logic got,
                      output item_t act, output item_t want);
    item_t e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_cin    = c;
    out_ready = rdy;
    #1;
    got  = 1'b0;
    acc  = in_valid && in_ready;
    act  = '0;
    want = '0;
    if (out_valid && out_ready) begin
      act.sum  = {32'd0, out_sum};
      act.cout = out_cout;
      act.ovf  = out_ovf;
      act.zero = out_zero;
      act.neg  = out_neg;
      act.cyc  = cyc;
      if (q32.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_underflow got unexpected sum=%h required no output", out_sum);
      end else begin
        want = q32.pop_front();
        got  = 1'b1;
      end
    end
    if (acc) begin
      e     = model({32'd0, a}, {32'd0, b}, op, c, 32);
      e.cyc = cyc;
      q32.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid got=%b required=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready);
    end
    checks++;
    if (out_sum !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_out_sum got=%h required=0", out_sum);
    end
    checks++;
    if ({out_cout, out_ovf, out_zero, out_neg} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b required=0000", {out_cout, out_ovf, out_zero, out_neg});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t  tv[8];
    logic  acc, got;
    item_t act, want;
    tv[0] = '{32'h0000_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0001_0000, 4'b0000};
    tv[1] = '{32'h0000_0005, 32'h0000_0005, 2'b01, 1'b0, 32'h0000_0000, 4'b1010};
    tv[2] = '{32'h0000_0003, 32'h0000_0005, 2'b01, 1'b1, 32'hFFFF_FFFE, 4'b0001};
    tv[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h8000_0000, 4'b0101};
    tv[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0000, 4'b1010};
    tv[5] = '{32'h0000_0001, 32'h0000_0001, 2'b00, 1'b1, 32'h0000_0002, 4'b0000};
    tv[6] = '{32'h0000_000A, 32'h0000_0003, 2'b11, 1'b0, 32'h0000_0006, 4'b1000};
    tv[7] = '{32'h8000_0000, 32'h0000_0001, 2'b11, 1'b1, 32'h7FFF_FFFF, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++)
        tick(1'b1, tv[i].a, tv[i].b, tv[i].op, tv[i].cin, 1'b1, acc, got, act, want);
      checks++;
      if (!acc) begin
        failures++;
        $display("[TB] FAIL directed_accept vec=%0d got in_ready=0 required accept", i);
      end
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++)
        tick(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1, acc, got, act, want);
      checks++;
      if (!got) begin
        failures++;
        $display("[TB] FAIL directed_timeout vec=%0d got no output required one", i);
      end else if (act.sum[31:0] !== tv[i].sum || {act.cout, act.ovf, act.zero, act.neg} !== tv[i].flags) begin
        failures++;
        $display("[TB] FAIL directed_result vec=%0d got sum=%h flags=%b required sum=%h flags=%b",
                 i, act.sum[31:0], {act.cout, act.ovf, act.zero, act.neg}, tv[i].sum, tv[i].flags);
      end
      if (got) begin
        checks++;
        if (act.cyc - want.cyc !== 4) begin
          failures++;
          $display("[TB] FAIL directed_latency vec=%0d got=%0d required=4", i, act.cyc - want.cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av[8], bv[8];
    logic        acc, got, rdy, prev_stall;
    logic [31:0] prev_sum;
    item_t       act, want;
    int          issued, retired, stalls, idx;
    for (int i = 0; i < 8; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom;
    end
    issued = 0;
    retired = 0;
    stalls = 0;
    prev_stall = 1'b0;
    prev_sum = '0;
    for (int t = 0; t < 80 && retired < 8; t++) begin
      rdy = !(t >= 5 && t < 8);
      idx = (issued < 8) ? issued : 7;
      tick(issued < 8, av[idx], bv[idx], 2'(idx % 4), idx[0], rdy, acc, got, act, want);
      if (acc) issued++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== prev_sum) begin
          failures++;
          $display("[TB] FAIL stall_hold got valid=%b sum=%h required valid=1 sum=%h", out_valid, out_sum, prev_sum);
        end
      end
      if (out_valid && !rdy) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL stall_in_ready got=%b required=0", in_ready);
        end
      end
      prev_stall = out_valid && !rdy;
      prev_sum = out_sum;
      if (got) begin
        retired++;
        checks++;
        if ({act.sum, act.cout, act.ovf, act.zero, act.neg} !== {want.sum, want.cout, want.ovf, want.zero, want.neg}) begin
          failures++;
          $display("[TB] FAIL b2b_result n=%0d got sum=%h flags=%b required sum=%h flags=%b", retired,
                   act.sum[31:0], {act.cout, act.ovf, act.zero, act.neg}, want.sum[31:0],
                   {want.cout, want.ovf, want.zero, want.neg});
        end
      end
    end
    checks++;
    if (issued !== 8 || retired !== 8 || q32.size() !== 0) begin
      failures++;
      $display("[TB] FAIL b2b_count got issued=%0d retired=%0d pending=%0d required 8/8/0", issued, retired, q32.size());
    end
    checks++;
    if (stalls !== 3) begin
      failures++;
      $display("[TB] FAIL b2b_stalls got=%0d required=3", stalls);
    end
  endtask

  task automatic test_reset_midflight();
    logic  acc, got, seen;
    item_t act, want;
    int    accepted;
    accepted = 0;
    for (int i = 0; i < 10 && accepted < 3; i++) begin
      tick(1'b1, 32'h100 + 32'(i), 32'h7, 2'b00, 1'b0, 1'b0, acc, got, act, want);
      if (acc) accepted++;
    end
    for (int t = 0; t < 10 && !out_valid; t++)
      tick(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, acc, got, act, want);
    checks++;
    if (out_valid !== 1'b1 || accepted !== 3) begin
      failures++;
      $display("[TB] FAIL midflight_fill got valid=%b accepted=%0d required 1/3", out_valid, accepted);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'd0) begin
      failures++;
      $display("[TB] FAIL midflight_reset got valid=%b sum=%h required 0/0", out_valid, out_sum);
    end
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1, acc, got, act, want);
      seen = seen | out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midflight_stale got out_valid=1 required none");
    end
  endtask

  task automatic test_param_sweep();
    item_t e;
    p8_out_ready  = 1'b1;
    p64_out_ready = 1'b1;
    for (int t = 0; t < 130; t++) begin
      @(negedge clk);
      p8_in_valid  = (t < 100) && ($urandom_range(0, 3) != 0);
      p8_in_a      = 8'($urandom);
      p8_in_b      = 8'($urandom);
      p8_in_op     = 2'($urandom);
      p8_in_cin    = 1'($urandom);
      p64_in_valid = (t < 100) && ($urandom_range(0, 3) != 0);
      p64_in_a     = {$urandom, $urandom};
      p64_in_b     = {$urandom, $urandom};
      p64_in_op    = 2'($urandom);
      p64_in_cin   = 1'($urandom);
      #1;
      if (p8_out_valid && p8_out_ready) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("[TB] FAIL w8_underflow got sum=%h required no output", p8_out_sum);
        end else begin
          e = q8.pop_front();
          if ({p8_out_sum, p8_out_cout, p8_out_ovf, p8_out_zero, p8_out_neg} !== {e.sum[7:0], e.cout, e.ovf, e.zero, e.neg}) begin
            failures++;
            $display("[TB] FAIL w8_result got sum=%h flags=%b required sum=%h flags=%b", p8_out_sum,
                     {p8_out_cout, p8_out_ovf, p8_out_zero, p8_out_neg}, e.sum[7:0], {e.cout, e.ovf, e.zero, e.neg});
          end
          checks++;
          if (cyc - e.cyc !== 1) begin
            failures++;
            $display("[TB] FAIL w8_latency got=%0d required=1", cyc - e.cyc);
          end
        end
      end
      if (p8_in_valid && p8_in_ready) begin
        e = model({56'd0, p8_in_a}, {56'd0, p8_in_b}, p8_in_op, p8_in_cin, 8);
        e.cyc = cyc;
        q8.push_back(e);
      end
      if (p64_out_valid && p64_out_ready) begin
        checks++;
        if (q64.size() == 0) begin
          failures++;
          $display("[TB] FAIL w64_underflow got sum=%h required no output", p64_out_sum);
        end else begin
          e = q64.pop_front();
          if ({p64_out_sum, p64_out_cout, p64_out_ovf, p64_out_zero, p64_out_neg} !== {e.sum, e.cout, e.ovf, e.zero, e.neg}) begin
            failures++;
            $display("[TB] FAIL w64_result got sum=%h flags=%b required sum=%h flags=%b", p64_out_sum,
                     {p64_out_cout, p64_out_ovf, p64_out_zero, p64_out_neg}, e.sum, {e.cout, e.ovf, e.zero, e.neg});
          end
          checks++;
          if (cyc - e.cyc !== 8) begin
            failures++;
            $display("[TB] FAIL w64_latency got=%0d required=8", cyc - e.cyc);
          end
        end
      end
      if (p64_in_valid && p64_in_ready) begin
        e = model(p64_in_a, p64_in_b, p64_in_op, p64_in_cin, 64);
        e.cyc = cyc;
        q64.push_back(e);
      end
    end
    checks++;
    if (q8.size() != 0 || q64.size() != 0) begin
      failures++;
      $display("[TB] FAIL sweep_leftover got pending w8=%0d w64=%0d required 0/0", q8.size(), q64.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_cin = 1'b0; out_ready = 1'b1;
    p8_in_valid = 1'b0; p8_in_a = '0; p8_in_b = '0; p8_in_op = '0; p8_in_cin = 1'b0; p8_out_ready = 1'b1;
    p64_in_valid = 1'b0; p64_in_a = '0; p64_in_b = '0; p64_in_op = '0; p64_in_cin = 1'b0; p64_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
